// File: rtl/qif_neuron_scheduler_pkg.sv
// Shared types, defaults and saturation helper for the time-multiplexed QIF neuron scheduler.
package qif_neuron_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam int NUM_NEURONS_DEF = 16;
  localparam int IDX_W_DEF       = 4;
  localparam int SQ_SHIFT_DEF    = 5;
  localparam int V_TH_DEF        = 50;
  localparam int V_RESET_DEF     = -20;

  function automatic logic signed [7:0] sat8(input logic signed [16:0] x);
    if (x > 17'sd127)
      return 8'h7F;
    else if (x < -17'sd128)
      return 8'h80;
    else
      return x[7:0];
  endfunction

endpackage

// File: rtl/qif_neuron_scheduler_if.sv
// Synaptic event input and spike output handshakes of the neuron scheduler.
interface qif_neuron_scheduler_if #(
  parameter int IDX_W = 4
);
  logic              ev_valid;
  logic              ev_ready;
  logic [IDX_W-1:0]  ev_idx;
  logic signed [7:0] ev_weight;
  logic              spk_valid;
  logic              spk_ready;
  logic [IDX_W-1:0]  spk_idx;

  modport master (
    output ev_valid, ev_idx, ev_weight, spk_ready,
    input  ev_ready, spk_valid, spk_idx
  );

  modport slave (
    input  ev_valid, ev_idx, ev_weight, spk_ready,
    output ev_ready, spk_valid, spk_idx
  );
endinterface

// File: rtl/qif_neuron_scheduler_update.sv
// Combinational QIF membrane update: Vn = sat8(V + (V*V >> SQ_SHIFT) + I), reset on fire.
module qif_update
  import qif_neuron_scheduler_pkg::*;
#(
  parameter int SQ_SHIFT = SQ_SHIFT_DEF,
  parameter int V_TH     = V_TH_DEF,
  parameter int V_RESET  = V_RESET_DEF
) (
  input  logic signed [7:0] v,
  input  logic signed [7:0] i,
  output logic signed [7:0] vn,
  output logic              fire
);
  logic signed [15:0] v_ext;
  logic signed [15:0] prod;
  logic [14:0]        sq;
  logic signed [16:0] s;
  logic signed [7:0]  vs;

  // V*V peaks at 16384 for V=-128, so it fits the positive range of 16 bits.
  always_comb begin
    v_ext = 16'(v);
    prod  = v_ext * v_ext;
    sq    = 15'($unsigned(prod) >> SQ_SHIFT);
    s     = 17'(v) + $signed({2'b00, sq}) + 17'(i);
    vs    = sat8(s);
    fire  = (vs >= V_TH);
    vn    = fire ? 8'(V_RESET) : vs;
  end
endmodule

// File: rtl/qif_neuron_scheduler.sv
// Sweeps NUM_NEURONS virtual QIF neurons through one shared update datapath on each tick.
module qif_neuron_scheduler
  import qif_neuron_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int SQ_SHIFT    = SQ_SHIFT_DEF,
  parameter int V_TH        = V_TH_DEF,
  parameter int V_RESET     = V_RESET_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  qif_neuron_scheduler_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic signed [7:0]      v_mon
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic signed [7:0] v_mem [NUM_NEURONS];
  logic signed [7:0] i_mem [NUM_NEURONS];
  logic signed [7:0] op_v, op_i, vn;
  logic              fire, wrote, ev_fire, wr_en;

  qif_update #(
    .SQ_SHIFT (SQ_SHIFT),
    .V_TH     (V_TH),
    .V_RESET  (V_RESET)
  ) u_update (
    .v    (op_v),
    .i    (op_i),
    .vn   (vn),
    .fire (fire)
  );

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    bus.ev_ready  = (state == IDLE);
    bus.spk_valid = (state == WRITE) && fire;
    bus.spk_idx   = bus.spk_valid ? idx : '0;
    busy          = (state != IDLE);
    done          = (state == DONE);
    unique case (state)
      IDLE:  if (tick) begin
               state_nxt = READ;
               idx_nxt   = '0;
             end
      READ:  state_nxt = WRITE;
      WRITE: if (!fire || bus.spk_ready) begin
               if (idx == LAST) begin
                 state_nxt = DONE;
               end else begin
                 state_nxt = READ;
                 idx_nxt   = idx + 1'b1;
               end
             end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ev_fire = bus.ev_valid && (state == IDLE);
  // A spike stall holds WRITE; the wrote flag keeps the write-back to the first cycle.
  assign wr_en   = (state == WRITE) && !wrote;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      op_v    <= '0;
      op_i    <= '0;
      wrote   <= 1'b0;
      overrun <= 1'b0;
      v_mon   <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      overrun <= tick && (state != IDLE);
      if (state == READ) begin
        op_v  <= v_mem[idx];
        op_i  <= i_mem[idx];
        wrote <= 1'b0;
      end
      if (wr_en) begin
        wrote <= 1'b1;
        v_mon <= vn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_mem <= '{default: '0};
      i_mem <= '{default: '0};
    end else begin
      if (wr_en) begin
        v_mem[idx] <= vn;
        i_mem[idx] <= '0;
      end else if (ev_fire) begin
        i_mem[bus.ev_idx] <= sat8(17'(i_mem[bus.ev_idx]) + 17'(bus.ev_weight));
      end
    end
  end
endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Directed bench for the QIF neuron scheduler with hand-computed membrane values.
module tb_qif_neuron_scheduler;
  localparam int N = 16;

  logic              clk;
  logic              rst_n;
  logic              tick;
  logic              busy;
  logic              done;
  logic              overrun;
  logic signed [7:0] v_mon;

  qif_neuron_scheduler_if #(.IDX_W(4)) bus ();

  qif_neuron_scheduler #(
    .NUM_NEURONS (N),
    .IDX_W       (4),
    .SQ_SHIFT    (5),
    .V_TH        (50),
    .V_RESET     (-20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .overrun (overrun),
    .v_mon   (v_mon)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int vlog [N];
  int ov_log [256];
  int spk_q [$];
  int stall_idx [8];
  int n_stall;
  int done_in_stall;
  int done_after;
  int cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_event(input int i, input int w);
    bus.ev_valid  = 1'b1;
    bus.ev_idx    = 4'(i);
    bus.ev_weight = 8'(w);
    @(posedge clk);
    @(negedge clk);
    bus.ev_valid  = 1'b0;
  endtask

  // Runs one sweep from a negedge; optional stall, extra tick and same-cycle event.
  task automatic sweep(input int stall, input int xtick, input int ev_en,
                       input int ev_i, input int ev_w, output int cycles);
    int stall_left;
    bit got_done;
    stall_left    = stall;
    n_stall       = 0;
    done_in_stall = 0;
    got_done      = 1'b0;
    cycles        = 0;
    spk_q.delete();
    for (int k = 0; k < N; k++) vlog[k] = 999;
    for (int k = 0; k < 256; k++) ov_log[k] = 0;
    tick          = 1'b1;
    bus.spk_ready = (stall == 0);
    if (ev_en != 0) begin
      bus.ev_valid  = 1'b1;
      bus.ev_idx    = 4'(ev_i);
      bus.ev_weight = 8'(ev_w);
    end
    while (!got_done && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      tick         = (cycles == xtick);
      bus.ev_valid = 1'b0;
      ov_log[cycles] = int'(overrun);
      if (cycles >= 3 && (cycles % 2) == 1 && (cycles - 3) / 2 < N)
        vlog[(cycles - 3) / 2] = int'(v_mon);
      if (bus.spk_valid) begin
        if (stall_left > 0) begin
          stall_idx[n_stall] = int'(bus.spk_idx);
          n_stall++;
          if (done) done_in_stall++;
          stall_left--;
        end else begin
          bus.spk_ready = 1'b1;
          spk_q.push_back(int'(bus.spk_idx));
        end
      end
      if (done) got_done = 1'b1;
    end
    if (!got_done) check("sweep_timeout", 0, 1);
    tick = 1'b0;
    bus.spk_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_after = int'(done);
  endtask

  initial begin
    rst_n         = 1'b0;
    tick          = 1'b0;
    bus.ev_valid  = 1'b0;
    bus.ev_idx    = '0;
    bus.ev_weight = '0;
    bus.spk_ready = 1'b1;
    #12;
    check("rst_ev_ready", int'(bus.ev_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_spk_valid", int'(bus.spk_valid), 0);
    check("rst_spk_idx", int'(bus.spk_idx), 0);
    check("rst_v_mon", int'(v_mon), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single event, plain sweep timing
    send_event(3, 10);
    sweep(0, 0, 0, 0, 0, cyc);
    check("t1_cycles", cyc, 33);
    check("t1_v3", vlog[3], 10);
    check("t1_v0", vlog[0], 0);
    check("t1_spikes", spk_q.size(), 0);
    check("t1_done_pulse", done_after, 0);
    check("t1_idle", int'(busy), 0);

    // 2: quadratic term only
    sweep(0, 0, 0, 0, 0, cyc);
    check("t2_v3", vlog[3], 13);
    check("t2_cycles", cyc, 33);

    // 3: drive V[5] to 40, fire, then recover
    do_reset();
    send_event(5, 40);
    sweep(0, 0, 0, 0, 0, cyc);
    check("t3_v5_pre", vlog[5], 40);
    check("t3_spk_none", spk_q.size(), 0);
    sweep(0, 0, 0, 0, 0, cyc);
    check("t3_spk_cnt", spk_q.size(), 1);
    if (spk_q.size() > 0) check("t3_spk_idx", spk_q[0], 5);
    check("t3_v5_reset", vlog[5], -20);
    sweep(0, 0, 0, 0, 0, cyc);
    check("t3_v5_next", vlog[5], -8);
    check("t3_spk_after", spk_q.size(), 0);

    // 4: saturating accumulation in both directions
    do_reset();
    send_event(0, 100);
    send_event(0, 100);
    send_event(1, -100);
    send_event(1, -100);
    sweep(0, 0, 0, 0, 0, cyc);
    check("t4_spk_cnt", spk_q.size(), 1);
    if (spk_q.size() > 0) check("t4_spk_idx", spk_q[0], 0);
    check("t4_v0", vlog[0], -20);
    check("t4_v1_neg_sat", vlog[1], -128);
    sweep(0, 0, 0, 0, 0, cyc);
    check("t4b_spk_cnt", spk_q.size(), 1);
    if (spk_q.size() > 0) check("t4b_spk_idx", spk_q[0], 1);
    check("t4b_v1", vlog[1], -20);
    check("t4b_v0", vlog[0], -8);

    // 5: back-pressure on the spike port
    do_reset();
    send_event(2, 60);
    send_event(9, 60);
    sweep(5, 0, 0, 0, 0, cyc);
    check("t5_cycles", cyc, 38);
    check("t5_stalls", n_stall, 5);
    for (int k = 0; k < 5; k++) check("t5_stall_idx", stall_idx[k], 2);
    check("t5_done_in_stall", done_in_stall, 0);
    check("t5_spk_cnt", spk_q.size(), 2);
    if (spk_q.size() == 2) begin
      check("t5_order0", spk_q[0], 2);
      check("t5_order1", spk_q[1], 9);
    end

    // 6: overrun with concurrent tick+event, then reset mid-sweep
    do_reset();
    sweep(0, 10, 1, 7, 20, cyc);
    check("t6_cycles", cyc, 33);
    check("t6_ov_before", ov_log[10], 0);
    check("t6_ov_pulse", ov_log[11], 1);
    check("t6_ov_after", ov_log[12], 0);
    check("t6_v7_same_cycle_ev", vlog[7], 20);
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t6_busy_mid", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_ev_ready", int'(bus.ev_ready), 1);
    check("t6_rst_spk_valid", int'(bus.spk_valid), 0);
    check("t6_rst_v_mon", int'(v_mon), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 0, 0, 0, 0, cyc);
    for (int k = 0; k < N; k++) check("t6_v_cleared", vlog[k], 0);
    check("t6_spk_none", spk_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
